// File: rtl/matrix_multiply_param_unit.sv
// matrix_multiply_param_unit: sequential NxN matrix multiplier, one multiply-accumulate per clock
module matrix_multiply_param_unit #(
    parameter int N     = 4,
    parameter int W     = 4,
    parameter int OUT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   signed_en,
    input  logic                   sat_en,
    input  logic [N*N*W-1:0]       matrixA,
    input  logic [N*N*W-1:0]       matrixB,
    output logic [N*N*OUT_W-1:0]   result,
    output logic                   busy,
    output logic                   listo,
    output logic                   ovf
);
    localparam int ACC_W = 2 * W + $clog2(N);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic [ACC_W:0] UMAX = (ONE << OUT_W) - ONE;
    localparam logic [ACC_W:0] SMAX = (ONE << (OUT_W - 1)) - ONE;
    localparam logic [ACC_W:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [N*N*W-1:0]     a_q, b_q;
    logic                 sgn_q, sat_q;
    logic [CW-1:0]        i_q, j_q, k_q;
    logic [ACC_W-1:0]     acc_q;
    logic                 sticky_q;
    logic [N*N*OUT_W-1:0] stage_q, stage_d;
    logic [N*N*OUT_W-1:0] result_q;
    logic                 ovf_q;

    logic [W-1:0]         a_el, b_el;
    logic [ACC_W-1:0]     a_ext, b_ext, sum;
    logic [ACC_W:0]       sum_ext, hi, lo;
    logic                 over, under;
    logic [OUT_W-1:0]     conv;
    logic                 k_last, j_last, i_last, last;

    assign k_last = k_q == CW'(N - 1);
    assign j_last = j_q == CW'(N - 1);
    assign i_last = i_q == CW'(N - 1);
    assign last   = state_q == CALC && k_last && j_last && i_last;

    assign result = result_q;
    assign ovf    = ovf_q;
    assign busy   = state_q != IDLE;
    assign listo  = state_q == DONE;

    // next state: DONE always returns to IDLE, so start during busy is simply dropped
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? CALC : IDLE) :
                  (state_q == CALC) ? (last ? DONE : CALC) : IDLE;
    end

    // operand fetch, MAC and range conversion; sum is widened by one bit so signed and unsigned share one compare
    always_comb begin
        a_el    = a_q[W * (int'(i_q) * N + int'(k_q)) +: W];
        b_el    = b_q[W * (int'(k_q) * N + int'(j_q)) +: W];
        a_ext   = sgn_q ? {{(ACC_W - W){a_el[W-1]}}, a_el} : {{(ACC_W - W){1'b0}}, a_el};
        b_ext   = sgn_q ? {{(ACC_W - W){b_el[W-1]}}, b_el} : {{(ACC_W - W){1'b0}}, b_el};
        sum     = acc_q + a_ext * b_ext;
        sum_ext = {sgn_q & sum[ACC_W-1], sum};
        hi      = sgn_q ? SMAX : UMAX;
        lo      = sgn_q ? SMIN : '0;
        over    = $signed(sum_ext) > $signed(hi);
        under   = $signed(sum_ext) < $signed(lo);
        conv    = (sat_q && over) ? hi[OUT_W-1:0] : (sat_q && under) ? lo[OUT_W-1:0] : sum[OUT_W-1:0];
        stage_d = stage_q;
        if (state_q == CALC && k_last) stage_d[OUT_W * (int'(i_q) * N + int'(j_q)) +: OUT_W] = conv;
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // capture on start, step the (i,j,k) walk in CALC, publish staging on the final MAC
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            sat_q    <= 1'b0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
            stage_q  <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else if (state_q == IDLE && start) begin
            a_q      <= matrixA;
            b_q      <= matrixB;
            sgn_q    <= signed_en;
            sat_q    <= sat_en;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            sticky_q <= 1'b0;
        end else if (state_q == CALC) begin
            acc_q    <= k_last ? '0 : sum;
            k_q      <= k_last ? '0 : k_q + 1'b1;
            j_q      <= k_last ? (j_last ? '0 : j_q + 1'b1) : j_q;
            i_q      <= (k_last && j_last) ? (i_last ? '0 : i_q + 1'b1) : i_q;
            sticky_q <= sticky_q | (k_last & (over | under));
            stage_q  <= stage_d;
            if (last) begin
                result_q <= stage_d;
                ovf_q    <= sticky_q | over | under;
            end
        end
    end
endmodule

// File: doc/matrix_multiply_param_unit.md
# matrix_multiply_param_unit

Parametrised, sequential N×N matrix multiplier computing R = A·B with one multiply-accumulate per clock. It is the next generation of the team's fixed 4×4, 4-bit multiplier. It adds:
- configurable dimension and element widths,
- a signed/unsigned mode and a saturate/truncate mode,
- input capture on start,
- a busy/listo handshake and an overflow flag.

It sits behind the accelerator's register/pin interface as a self-contained compute block.

## Interface
- N, default 4: matrix dimension, N ≥ 1.
- W, default 4: input element width, W ≥ 2.
- OUT_W, default 4: result element width, 1 ≤ OUT_W ≤ ACC_W.
- ACC_W (derived, not overridable): 2·W + $clog2(N); internal accumulator width.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- signed_en  input  1  1 = two's-complement elements, 0 = unsigned; captured on start.
- sat_en  input  1  1 = saturate results to OUT_W, 0 = keep the low OUT_W bits; captured on start.
- matrixA  input  N·N·W  element (r,c) at bits [W·(r·N+c) +: W].
- matrixB  input  N·N·W  same packing as matrixA.
- result  output  N·N·OUT_W  element (r,c) at bits [OUT_W·(r·N+c) +: OUT_W]; registered.
- busy  output  1  high in CALC and DONE.
- listo  output  1  one-cycle completion pulse.
- ovf  output  1  at least one element of the last completed operation was not representable in OUT_W.

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on start=1:
  - capture matrixA, matrixB, signed_en and sat_en into internal registers;
  - clear i, j, k, the accumulator and the sticky overflow.
  - After capture, the input ports are don't-care until the next IDLE.
- CALC, each cycle:
  - sum = acc + A[i][k]·B[k][j], with operands sign- or zero-extended to ACC_W per the captured mode.
  - If k < N−1: acc ← sum, k ← k+1.
  - If k = N−1: convert sum, write it to staging element (i,j), set acc ← 0 and k ← 0, then advance j, wrapping to 0 and incrementing i.
  - When i = N−1, j = N−1 and k = N−1: go to DONE.
- Conversion, unsigned:
  - representable iff sum < 2^OUT_W;
  - saturate → 2^OUT_W−1.
- Conversion, signed:
  - representable iff −2^(OUT_W−1) ≤ sum ≤ 2^(OUT_W−1)−1;
  - saturate to the nearer bound.
- Conversion, truncate mode: always keep sum[OUT_W−1:0].
- Overflow: a non-representable sum sets the sticky overflow in either mode.
- DONE:
  - result ← staging buffer, ovf ← sticky overflow, listo = 1;
  - next state is IDLE unconditionally.
- result and ovf hold their values from one DONE until the next DONE. They are not cleared by a new start.
- The accumulator never overflows, because ACC_W covers N products.

## Timing
- Reset (async assert, any state):
  - state = IDLE;
  - result = 0, busy = 0, listo = 0, ovf = 0;
  - counters, accumulator and staging buffer = 0;
  - an in-flight operation is discarded and produces no listo.
- Reset release: the first start is accepted on the first rising edge with rst = 1.
- Latency, with start sampled at edge t0:
  - busy = 1 from t0;
  - edge t0+N³ enters DONE: result/ovf update and listo = 1 for exactly one cycle;
  - edge t0+N³+1: IDLE, busy = 0, listo = 0.
  - Default N=4: listo during cycle 64 after the start edge.
- start while busy (CALC or DONE) is ignored and not queued.
- start held high continuously re-triggers only in the IDLE cycle after DONE, giving a back-to-back period of N³+2 cycles.

## Test plan
- Identity, N=4, W=4, OUT_W=4, unsigned, sat_en=0: A = identity (diagonal 0x1), B all 0x3 → every result element 0x3, ovf=0, listo exactly 64 cycles after the start edge, busy high 65 cycles.
- Truncate versus saturate, unsigned: A and B all 0xF (sum = 900 = 0x384).
  - sat_en=0 → all elements 0x4, ovf=1.
  - sat_en=1 → all elements 0xF, ovf=1.
- Signed: A all 0x8 (−8), B all 0x8 (sum = +256).
  - sat_en=1 → all elements 0x7, ovf=1.
  - sat_en=0 → all elements 0x0, ovf=1.
  - Separately, A all 0xF (−1), B = identity, sat_en=1 → all elements 0xF, ovf=0.
- Capture/handshake: start held high. matrixA changes to all 0x0 one cycle after capture → result still reflects the captured values. Second operation starts the cycle after listo. Previous result is held during the second computation. listo is one cycle per operation.
- Reset mid-operation: rst low at cycle 30 of CALC → result=0, busy=0, listo=0, ovf=0 immediately and asynchronously; no listo is produced. Restarting the identity case completes correctly in 64 cycles.
- Parameter sweep: N=1, W=8, OUT_W=16, signed, A=0x80, B=0x80 → result 0x4000, ovf=0, listo 1 cycle after start. Also N=3, W=4, OUT_W=10 against a reference model on random matrices.
